// File: rtl/spi_slave_ctrl_if.sv
// ============================================================================
//  Module   : spi_slave_ctrl_if
//  Brief    : SPI pins plus the RAM-side word/byte handshake of spi_slave_ctrl.
//             frame_err exists only when SPI_FRAME_ERR_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface spi_slave_ctrl_if #(
    parameter int RX_W = 10,
    parameter int TX_W = 8
);
    logic            SS_n;
    logic            MOSI;
    logic            MISO;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid;
    logic [TX_W-1:0] tx_data;
    logic            tx_valid;
`ifdef SPI_FRAME_ERR_EN
    logic            frame_err;
`endif

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
`ifdef SPI_FRAME_ERR_EN
        output frame_err,
`endif
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
`ifdef SPI_FRAME_ERR_EN
        input  frame_err,
`endif
        input  MISO, rx_data, rx_valid
    );
endinterface

`default_nettype wire

// File: rtl/spi_slave_ctrl.sv
// ============================================================================
//  Module   : spi_slave_ctrl
//  Brief    : SPI slave front end: deserializes {cmd,byte} words for the RAM and
//             serializes the RAM read byte on MISO. Optional SPI_FRAME_ERR_EN
//             adds a one-cycle frame_err strobe on aborted frames.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_slave_ctrl #(
    parameter int RX_W = 10,
    parameter int TX_W = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    spi_slave_ctrl_if.slave bus
);
    localparam int c_cnt_w = $clog2(RX_W + 1);
    localparam int c_txc_w = $clog2(TX_W + 2);
    localparam logic [c_cnt_w-1:0] c_rx_last = c_cnt_w'(RX_W - 1);
    localparam logic [c_cnt_w-1:0] c_rx_full = c_cnt_w'(RX_W);
    localparam logic [c_txc_w-1:0] c_tx_load = c_txc_w'(1);
    localparam logic [c_txc_w-1:0] c_tx_end  = c_txc_w'(TX_W + 1);

    localparam logic [2:0] c_idle      = 3'd0;
    localparam logic [2:0] c_chk_cmd   = 3'd1;
    localparam logic [2:0] c_write     = 3'd2;
    localparam logic [2:0] c_read_add  = 3'd3;
    localparam logic [2:0] c_read_data = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [c_cnt_w-1:0] bit_cnt_q, bit_cnt_d;
    logic [RX_W-2:0]    rx_sr_q, rx_sr_d;
    logic [RX_W-1:0]    rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rd_addr_done_q, rd_addr_done_d;
    logic [TX_W-1:0]    tx_sr_q, tx_sr_d;
    logic [c_txc_w-1:0] tx_cnt_q, tx_cnt_d;
    logic               miso_q, miso_d;
`ifdef SPI_FRAME_ERR_EN
    logic               frame_err_q, frame_err_d;
`endif

    logic w_data_state;
    logic w_rx_done;

    assign w_data_state = (state_q == c_write) || (state_q == c_read_add) ||
                          (state_q == c_read_data);
    assign w_rx_done    = (bit_cnt_q == c_rx_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= c_idle;
            bit_cnt_q      <= '0;
            rx_sr_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_done_q <= 1'b0;
            tx_sr_q        <= '0;
            tx_cnt_q       <= '0;
            miso_q         <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_sr_q        <= rx_sr_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_done_q <= rd_addr_done_d;
            tx_sr_q        <= tx_sr_d;
            tx_cnt_q       <= tx_cnt_d;
            miso_q         <= miso_d;
`ifdef SPI_FRAME_ERR_EN
            frame_err_q    <= frame_err_d;
`endif
        end
    end

    // The select bit is consumed here only to pick the path; it never enters the word.
    always_comb begin
        state_d = state_q;
        if (bus.SS_n) begin
            state_d = c_idle;
        end else begin
            case (state_q)
                c_idle:    state_d = c_chk_cmd;
                c_chk_cmd: begin
                    if (!bus.MOSI)          state_d = c_write;
                    else if (rd_addr_done_q) state_d = c_read_data;
                    else                    state_d = c_read_add;
                end
                c_write, c_read_add, c_read_data: state_d = state_q;
                default:   state_d = c_idle;
            endcase
        end
    end

    // tx_cnt: 0 = waiting for RAM byte, 1..TX_W = shifting, TX_W+1 = byte fully sent.
    always_comb begin
        bit_cnt_d      = bit_cnt_q;
        rx_sr_d        = rx_sr_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_done_d = rd_addr_done_q;
        tx_sr_d        = tx_sr_q;
        tx_cnt_d       = tx_cnt_q;
        miso_d         = miso_q;
        if (bus.SS_n || !w_data_state) begin
            bit_cnt_d = '0;
            tx_cnt_d  = '0;
            miso_d    = 1'b0;
        end else if (!w_rx_done) begin
            rx_sr_d   = {rx_sr_q[RX_W-3:0], bus.MOSI};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == c_rx_last) begin
                rx_data_d  = {rx_sr_q, bus.MOSI};
                rx_valid_d = 1'b1;
                if (state_q == c_read_add)  rd_addr_done_d = 1'b1;
                if (state_q == c_read_data) rd_addr_done_d = 1'b0;
            end
        end else if (state_q == c_read_data) begin
            if (tx_cnt_q == '0) begin
                if (bus.tx_valid) begin
                    tx_sr_d  = bus.tx_data;
                    tx_cnt_d = c_tx_load;
                end
            end else if (tx_cnt_q != c_tx_end) begin
                miso_d   = tx_sr_q[TX_W-1];
                tx_sr_d  = {tx_sr_q[TX_W-2:0], 1'b0};
                tx_cnt_d = tx_cnt_q + 1'b1;
            end else begin
                miso_d = 1'b0;
            end
        end
    end

`ifdef SPI_FRAME_ERR_EN
    always_comb begin
        frame_err_d = bus.SS_n && w_data_state &&
                      (!w_rx_done || ((state_q == c_read_data) && (tx_cnt_q != c_tx_end)));
    end

    assign bus.frame_err = frame_err_q;
`endif

    assign bus.MISO     = miso_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_ctrl.sv
// ============================================================================
//  Module   : tb_spi_slave_ctrl
//  Brief    : Frame-level reference model of spi_slave_ctrl with randomized
//             frames, aborts and stray tx_valid, checked every cycle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_ctrl;
    localparam int SZ = 8192;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    spi_slave_ctrl_if #(.RX_W(10), .TX_W(8)) bus ();

    spi_slave_ctrl #(.RX_W(10), .TX_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs indexed by the clock edge that produces them.
    bit         exp_rxv  [SZ];
    logic [9:0] exp_word [SZ];
    bit         exp_miso [SZ];
`ifdef SPI_FRAME_ERR_EN
    bit         exp_ferr [SZ];
`endif
    bit         pin_rx_en  [SZ];
    logic [9:0] pin_rx     [SZ];
    bit         pin_miso_en[SZ];
    bit         pin_miso   [SZ];
    bit         pin_bits   [8];
    bit         rd_done = 1'b0;
    logic [9:0] mdl_rx  = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            mdl_rx = '0;
            chk("rst_miso", 32'(bus.MISO), 32'd0);
            chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
            chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
`ifdef SPI_FRAME_ERR_EN
            chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
`endif
        end else if (cyc < SZ) begin
            if (exp_rxv[cyc]) mdl_rx = exp_word[cyc];
            chk("rx_valid", 32'(bus.rx_valid), 32'(exp_rxv[cyc]));
            chk("rx_data", 32'(bus.rx_data), 32'(mdl_rx));
            chk("miso", 32'(bus.MISO), 32'(exp_miso[cyc]));
`ifdef SPI_FRAME_ERR_EN
            chk("frame_err", 32'(bus.frame_err), 32'(exp_ferr[cyc]));
`endif
            if (pin_rx_en[cyc])
                chk("pin_rx_word", 32'({bus.rx_valid, bus.rx_data}), 32'({1'b1, pin_rx[cyc]}));
            if (pin_miso_en[cyc])
                chk("pin_miso", 32'(bus.MISO), 32'(pin_miso[cyc]));
        end
    end

    // One SS_n-low frame: len edges with SS_n low (edge 0 wakes IDLE, edge 1 is the
    // select bit, edges 2..11 carry the word). For a read-data frame the RAM answers
    // gap edges after the word is complete. rst_k >= 0 resets right after edge rst_k.
    task automatic frame(input bit sel, input logic [9:0] word, input int len, input int gap,
                         input logic [7:0] txbyte, input int rst_k,
                         input bit pin_w_en, input logic [9:0] pin_w, input bit pin_m_en);
        int s, t, path;
        bit complete, loaded;
        @(negedge clk);
        s        = cyc + 1;
        path     = !sel ? 0 : (rd_done ? 2 : 1);
        complete = (len >= 12);
        t        = s + 12 + gap;
        loaded   = (path == 2) && complete && (t < s + len);
        if (complete) begin
            exp_rxv[s+11]  = 1'b1;
            exp_word[s+11] = word;
            if (path == 1) rd_done = 1'b1;
            if (path == 2) rd_done = 1'b0;
        end
        if (loaded)
            for (int j = 1; j <= 8; j++)
                if (t + j < s + len) exp_miso[t+j] = txbyte[8-j];
`ifdef SPI_FRAME_ERR_EN
        if (len >= 2 && (!complete || (path == 2 && !(loaded && s + len >= t + 9))))
            exp_ferr[s+len] = 1'b1;
`endif
        if (pin_w_en) begin
            pin_rx_en[s+11] = 1'b1;
            pin_rx[s+11]    = pin_w;
        end
        if (pin_m_en)
            for (int j = 1; j <= 8; j++) begin
                pin_miso_en[t+j] = 1'b1;
                pin_miso[t+j]    = pin_bits[j-1];
            end
        for (int k = 0; k < len; k++) begin
            bus.SS_n    = 1'b0;
            bus.MOSI    = (k == 1) ? sel : ((k >= 2 && k <= 11) ? word[11-k] : 1'($urandom));
            bus.tx_data = (path == 2 && k == 12 + gap) ? txbyte : 8'($urandom);
            if (path == 2 && k >= 12 && k <= 12 + gap) bus.tx_valid = (k == 12 + gap);
            else                                       bus.tx_valid = ($urandom_range(0, 3) == 0);
            if (k == rst_k) begin
                @(posedge clk);
                #1;
                rst_n    = 1'b0;
                bus.SS_n = 1'b1;
                rd_done  = 1'b0;
                for (int i = s + k; i < SZ; i++) begin
                    exp_rxv[i]  = 1'b0;
                    exp_miso[i] = 1'b0;
`ifdef SPI_FRAME_ERR_EN
                    exp_ferr[i] = 1'b0;
`endif
                end
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
        end
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'($urandom);
        bus.tx_valid = ($urandom_range(0, 3) == 0);
        bus.tx_data  = 8'($urandom);
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            bus.MOSI     = 1'($urandom);
            bus.tx_valid = ($urandom_range(0, 3) == 0);
            bus.tx_data  = 8'($urandom);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, gap;
        pin_bits     = '{1, 0, 1, 0, 0, 1, 0, 1};
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // stray RAM strobes while idle
        repeat (4) begin
            @(negedge clk);
            bus.tx_valid = 1'b1;
            bus.tx_data  = 8'hFF;
        end
        frame(0, 10'h02A, 14, 0, 8'h00, -1, 1, 10'h02A, 0);
        frame(0, 10'h1A5, 13, 0, 8'h00, -1, 1, 10'h1A5, 0);
        frame(1, 10'h22A, 14, 0, 8'h00, -1, 1, 10'h22A, 0);
        frame(1, 10'h3C3, 24, 2, 8'hA5, -1, 1, 10'h3C3, 1);
        frame(0, 10'h3FF, 7, 0, 8'h00, -1, 0, 10'h000, 0);
        frame(0, 10'h155, 14, 0, 8'h00, -1, 1, 10'h155, 0);
        frame(1, 10'h2B3, 14, 0, 8'h00, -1, 0, 10'h000, 0);
        frame(1, 10'h3EE, 17, 0, 8'h5A, -1, 0, 10'h000, 0);
        frame(1, 10'h2B3, 14, 0, 8'h00, -1, 0, 10'h000, 0);
        frame(1, 10'h300, 30, 0, 8'hFF, 15, 0, 10'h000, 0);
        frame(1, 10'h0F0, 14, 0, 8'h00, -1, 0, 10'h000, 0);
        frame(1, 10'h3AB, 24, 1, 8'h3C, -1, 0, 10'h000, 0);

        for (int n = 0; n < 150 && cyc < SZ - 64; n++) begin
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 11))
                                              : int'($urandom_range(12, 30));
            gap = int'($urandom_range(0, 3));
            frame(1'($urandom), 10'($urandom), len, gap, 8'($urandom), -1, 0, 10'h000, 0);
        end
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
